// File: rtl/envelope_shaper_if.sv
// Sample stream and ADSR control bundle between the note player, sine reader,
// envelope shaper and the codec/mixer.
interface envelope_shaper_if #(
    parameter int SAMPLE_WIDTH = 16
);
    logic                           note_on;
    logic [7:0]                     attack_step;
    logic [7:0]                     decay_step;
    logic [7:0]                     sustain_level;
    logic [7:0]                     release_step;
    logic signed [SAMPLE_WIDTH-1:0] sample_in;
    logic                           sample_in_ready;
    logic signed [SAMPLE_WIDTH-1:0] sample_out;
    logic                           sample_out_ready;
    logic [7:0]                     env;
    logic                           active;

    modport master (
        output note_on, attack_step, decay_step, sustain_level, release_step,
        output sample_in, sample_in_ready,
        input  sample_out, sample_out_ready, env, active
    );

    modport slave (
        input  note_on, attack_step, decay_step, sustain_level, release_step,
        input  sample_in, sample_in_ready,
        output sample_out, sample_out_ready, env, active
    );
endinterface

// File: rtl/envelope_shaper.sv
// ADSR amplitude envelope applied to a signed sample stream; the envelope
// advances once per input sample tick and the scaling datapath is two stages.
module envelope_shaper #(
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    envelope_shaper_if.slave bus
);
    localparam int PROD_W = SAMPLE_WIDTH + 9;

    typedef enum logic [2:0] {
        S_IDLE, S_ATTACK, S_DECAY, S_SUSTAIN, S_RELEASE
    } state_t;

    state_t r_state, w_state_edge, w_state_next;
    logic [7:0] r_env, w_env_next;
    logic r_note_prev, r_active;
    logic w_tick, w_rise, w_fall;
    logic [8:0] w_sum, w_diff_dec, w_diff_rel;
    logic signed [PROD_W-1:0] w_smp_ext, w_env_ext, w_prod, r_prod_p1;
    logic r_vld_p1, r_vld_p2;
    logic signed [SAMPLE_WIDTH-1:0] r_out_p2;

    // Product >>> 8 (floor), clamped to the output range as a guard.
    function automatic logic signed [SAMPLE_WIDTH-1:0] scale_shift(
        input logic signed [PROD_W-1:0] p
    );
        logic signed [PROD_W-1:0] s, lim_hi, lim_lo;
        s      = p >>> 8;
        lim_hi = {{(PROD_W-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
        lim_lo = ~lim_hi;
        if (s > lim_hi)      return lim_hi[SAMPLE_WIDTH-1:0];
        else if (s < lim_lo) return lim_lo[SAMPLE_WIDTH-1:0];
        else                 return s[SAMPLE_WIDTH-1:0];
    endfunction

    assign w_tick     = bus.sample_in_ready;
    assign w_sum      = {1'b0, r_env} + {1'b0, bus.attack_step};
    assign w_diff_dec = {1'b0, r_env} - {1'b0, bus.decay_step};
    assign w_diff_rel = {1'b0, r_env} - {1'b0, bus.release_step};

    always_comb begin
        w_rise       = bus.note_on & ~r_note_prev;
        w_fall       = ~bus.note_on & r_note_prev;
        w_state_edge = r_state;
        if (w_rise)
            w_state_edge = S_ATTACK;
        else if (w_fall && r_state != S_IDLE && r_state != S_RELEASE)
            w_state_edge = S_RELEASE;

        // Tick arithmetic runs on the post-edge state.
        w_state_next = w_state_edge;
        w_env_next   = r_env;
        if (w_tick) begin
            case (w_state_edge)
                S_ATTACK: begin
                    if (bus.attack_step == 8'd0 || w_sum >= 9'd255) begin
                        w_env_next   = 8'd255;
                        w_state_next = S_DECAY;
                    end else begin
                        w_env_next = w_sum[7:0];
                    end
                end
                S_DECAY: begin
                    if (bus.decay_step == 8'd0 || r_env <= bus.sustain_level ||
                        w_diff_dec[8] || w_diff_dec[7:0] <= bus.sustain_level) begin
                        w_env_next   = bus.sustain_level;
                        w_state_next = S_SUSTAIN;
                    end else begin
                        w_env_next = w_diff_dec[7:0];
                    end
                end
                S_SUSTAIN: w_env_next = bus.sustain_level;
                S_RELEASE: begin
                    if (bus.release_step == 8'd0 || w_diff_rel[8] ||
                        w_diff_rel[7:0] == 8'd0) begin
                        w_env_next   = 8'd0;
                        w_state_next = S_IDLE;
                    end else begin
                        w_env_next = w_diff_rel[7:0];
                    end
                end
                default: w_env_next = 8'd0;
            endcase
        end
    end

    // Stage 1: sample times zero-extended envelope (pre-update value)
    assign w_smp_ext = {{9{bus.sample_in[SAMPLE_WIDTH-1]}}, bus.sample_in};
    assign w_env_ext = {{(PROD_W-8){1'b0}}, r_env};
    assign w_prod    = w_smp_ext * w_env_ext;

    always_ff @(posedge clk) begin
        if (w_tick) r_prod_p1 <= w_prod;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_env       <= 8'd0;
            r_note_prev <= 1'b0;
            r_active    <= 1'b0;
            r_vld_p1    <= 1'b0;
            r_vld_p2    <= 1'b0;
            r_out_p2    <= '0;
        end else begin
            r_state     <= w_state_next;
            r_env       <= w_env_next;
            r_note_prev <= bus.note_on;
            r_active    <= (w_state_next != S_IDLE);
            r_vld_p1    <= w_tick;
            // Stage 2: scaled output, held between pulses
            r_vld_p2    <= r_vld_p1;
            if (r_vld_p1) r_out_p2 <= scale_shift(r_prod_p1);
        end
    end

    assign bus.sample_out       = r_out_p2;
    assign bus.sample_out_ready = r_vld_p2;
    assign bus.env              = r_env;
    assign bus.active           = r_active;
endmodule

// File: doc/envelope_shaper.md
Name: envelope_shaper

Overview:
- Sits directly downstream of the sine sample reader and consumes its 16-bit signed samples and sample-ready pulses.
- Applies an 8-bit ADSR amplitude envelope, with Attack, Decay, Sustain and Release phases, gated by a note_on level from the note player.
- Emits scaled samples with a matching ready pulse toward the codec/mixer.
- Envelope arithmetic advances once per input sample tick.

Parameters:
SAMPLE_WIDTH, 16, width of signed sample_in/sample_out

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high; clears all state
note_on  input  1  level; high while note held
attack_step  input  8  env increment per tick in ATTACK; 0 = jump to 255
decay_step  input  8  env decrement per tick in DECAY; 0 = jump to sustain_level
sustain_level  input  8  env hold level in SUSTAIN
release_step  input  8  env decrement per tick in RELEASE; 0 = jump to 0
sample_in  input  SAMPLE_WIDTH  signed two's-complement sample
sample_in_ready  input  1  one-cycle pulse, sample_in valid
sample_out  output  SAMPLE_WIDTH  signed scaled sample
sample_out_ready  output  1  one-cycle pulse, sample_out valid
env  output  8  current envelope value, unsigned
active  output  1  high when state != IDLE

Behaviour:
- Reset (async): state=IDLE, env=0, sample_out=0, sample_out_ready=0, edge-detect register=0; pipeline valids cleared.
- note_on edge detect: previous level registered every clk.
  - Rising edge: state->ATTACK from any state. env is not cleared; retrigger continues from the current env.
  - Falling edge: state->RELEASE from ATTACK/DECAY/SUSTAIN. IDLE stays IDLE.
  - Edges act on the cycle they are seen, independent of ticks.
- Tick = sample_in_ready high. env updates only on ticks, using the state after any same-cycle edge transition. A rising edge together with a tick means ATTACK arithmetic applies that tick.
- Per-state tick update:
  - ATTACK: env = min(env+attack_step, 255). Reaching 255 -> DECAY. attack_step=0 -> env=255, ->DECAY.
  - DECAY: env = max(env-decay_step, sustain_level). Reaching sustain_level -> SUSTAIN. decay_step=0 -> env=sustain_level, ->SUSTAIN. If env is already <= sustain_level on entry -> env=sustain_level, ->SUSTAIN.
  - SUSTAIN: env = sustain_level, tracking live changes of sustain_level.
  - RELEASE: env = max(env-release_step, 0). Reaching 0 -> IDLE. release_step=0 -> env=0, ->IDLE.
  - IDLE: env held at 0.
- All saturation uses 9-bit intermediates; env never wraps.
- Datapath: fully pipelined, accepts a tick every cycle.
  - Stage 1, on tick: product = sample_in (signed) * {1'b0,env} (signed 9-bit), using env before this tick's update. Stored in a 25-bit register, with valid.
  - Stage 2: sample_out = product >>> 8, arithmetic shift with truncation toward -inf, taking bits [23:8]. Registered; sample_out_ready pulses.
  - Latency: sample_out_ready is high exactly 2 cycles after sample_in_ready, one pulse per input pulse. sample_out holds its value between pulses.
- Max magnitude: 32767*255>>8 = 32639, so no output overflow is possible.
- Reset mid-operation: in-flight samples are dropped and no ready pulse is emitted after reset.
- active is a registered decode of state.

Test Plan:
- Attack ramp: reset, attack_step=64, decay_step=16, sustain_level=200, note_on=1, ticks every 4 clk -> env after ticks 0,64,128,192,255(sat); state DECAY; then 239,223,207,200; then SUSTAIN holds 200.
- Scaling/latency: env=128, sample_in=16'h4000 tick at cycle t -> sample_out=16'h2000 (8192), sample_out_ready high only at t+2. sample_in=-16384 with env=255 -> -16320.
- Release to idle: in SUSTAIN env=200, drop note_on, release_step=100 -> env 100, 0; active falls and state=IDLE on the second tick; later ticks give sample_out=0.
- Zero-step boundaries: attack_step=0 -> env=255 on the first tick; decay_step=0 -> env=sustain_level next tick; release_step=0 -> env=0 and IDLE on the first release tick.
- Retrigger/simultaneous: in RELEASE with env=80, raise note_on on the same cycle as a tick with attack_step=50 -> env=130, state ATTACK. Back-to-back ticks on consecutive cycles -> back-to-back sample_out_ready pulses with correct per-sample env.
- Async reset mid-pipeline: assert reset one cycle after a tick -> outputs go to 0 immediately without a clock edge; no sample_out_ready pulse follows.
